// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

endpackage : mips_pkg

// File: rtl/mips_ifetch_pc_reg.sv
// Enable-load register holding the fetch PC; async active-low reset to RESET_VAL.
module pc_reg #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule : pc_reg

// File: rtl/mips_ifetch.sv
// Instruction-fetch stage: PC, imem req/ack, instruction register, redirect/squash.
// Optional macro IFETCH_ALIGN_CHECK_EN traps misaligned redirects into a sticky FAULT state.
module mips_ifetch #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic                      imem_req,
    output logic [mips_pkg::XLEN-1:0] imem_addr,
    input  logic                      imem_ack,
    input  logic [mips_pkg::XLEN-1:0] imem_rdata,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [mips_pkg::XLEN-1:0] instr,
    output logic [mips_pkg::XLEN-1:0] pcplus4,
    input  logic                      redirect_valid,
    input  logic [mips_pkg::XLEN-1:0] redirect_pc,
    output logic                      fetch_fault
);

    import mips_pkg::*;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(WORD_BYTES);

    fetch_state_t    state_q, state_d;
    logic            squash_q, squash_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_en;
    logic [XLEN-1:0] redirect_pc_c;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic misalign_c;

    assign redirect_pc_c = redirect_pc;
    assign misalign_c    = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    // Without the check the low address bits are simply dropped.
    assign redirect_pc_c = redirect_pc & ~XLEN'(WORD_BYTES - 1);
`endif

    pc_reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (reset_n),
        .en_i  (pc_en),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    // Next-state, PC update and registered-output decode.
    always_comb begin
        state_d  = state_q;
        squash_d = squash_q;
        req_d    = req_q;
        addr_d   = addr_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pcp4_d   = pcp4_q;
        pc_d     = pc_q;
        pc_en    = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        fault_d  = fault_q;
`endif

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect_valid) begin
                    pc_en = 1'b1;
                    pc_d  = redirect_pc_c;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_en    = 1'b1;
                        pc_d     = redirect_pc_c;
                        squash_d = 1'b0;
                    end else if (squash_q) begin
                        squash_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        pcp4_d  = pc_q + PC_STEP;
                        pc_en   = 1'b1;
                        pc_d    = pc_q + PC_STEP;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    // Request stays on the bus; its data will be dropped.
                    pc_en    = 1'b1;
                    pc_d     = redirect_pc_c;
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_d = FETCH;
                end
                if (redirect_valid) begin
                    pc_en = 1'b1;
                    pc_d  = redirect_pc_c;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef IFETCH_ALIGN_CHECK_EN
        if (misalign_c && (state_q != FAULT)) begin
            state_d  = FAULT;
            fault_d  = 1'b1;
            squash_d = 1'b0;
            pc_en    = 1'b0;
            pc_d     = pc_q;
        end
`endif

        // A new request launches on entering FETCH or after any ack; an unacked one is held.
        if (state_d == FETCH) begin
            req_d = 1'b1;
            if (!((state_q == FETCH) && !imem_ack)) begin
                addr_d = pc_d;
            end
        end else begin
            req_d = 1'b0;
        end
        valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            squash_q <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pcp4_q   <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pcp4_q   <= pcp4_d;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q  <= fault_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pcplus4     = pcp4_q;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule : mips_ifetch
